// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one external memory port between the instruction-fetch path and the
// load/store data path. Each access runs IDLE -> FETCH/DATA -> DONE -> IDLE.
// Simultaneous requests are arbitrated round-robin. An access whose strobe sits
// on a busy bus for TIMEOUT cycles is aborted and reported through err.
// stall is purely combinational from the request and ready signals so the
// core can freeze its PC and writeback in the same cycle it raises a request.

module mem_port_arbiter #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic [31:0] i_rdata,
    output logic        i_ready,

    input  logic        d_ren,
    input  logic        d_wen,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_ready,

    output logic        bus_ren,
    output logic        bus_wen,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic [31:0] bus_rdata,
    input  logic        bus_busy,

    output logic        stall,
    output logic        err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DATA  = 2'd2,
        DONE  = 2'd3
    } state_t;

    // The wait counter is 8 bits wide; TIMEOUT is limited to 1..255 so the
    // abort always fires before the counter could wrap.
    localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

    state_t      state;
    state_t      state_nx;

    logic        d_req;
    logic        in_access;
    logic        in_done;

    // Arbitration / sequencing strobes produced by the next-state logic.
    logic        start;        // IDLE -> FETCH/DATA this cycle
    logic        pick_d;       // granted side at start: 1 = data, 0 = fetch
    logic        complete;     // strobe accepted by the bus this cycle
    logic        timed_out;    // wait budget exhausted this cycle

    logic        grant_d;      // side owning the current access (1 = data)
    logic        last_grant_d; // side that owned the previous access
    logic        aborted;      // current access ended by timeout
    logic [7:0]  wait_cnt;     // busy cycles spent in FETCH/DATA

    logic [31:0] hold_q;       // read data (or 0) of the finishing access
    logic [31:0] i_rdata_q;    // last value delivered to the fetch side
    logic [31:0] d_rdata_q;    // last value delivered to the data side

    // A simultaneous read and write request is handled as a write.
    assign d_req     = d_ren | d_wen;
    assign in_access = (state == FETCH) || (state == DATA);
    assign in_done   = (state == DONE);

    // State register; reset returns to IDLE immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic: round-robin grant in IDLE, completion or abort in FETCH/DATA.
    always_comb begin
        state_nx  = state;
        start     = 1'b0;
        pick_d    = 1'b0;
        complete  = 1'b0;
        timed_out = 1'b0;

        unique case (state)
            IDLE: begin
                if (i_req && d_req) begin
                    // Tie: the side that did not win last time goes first.
                    start  = 1'b1;
                    pick_d = ~last_grant_d;
                end else if (i_req) begin
                    start  = 1'b1;
                    pick_d = 1'b0;
                end else if (d_req) begin
                    start  = 1'b1;
                    pick_d = 1'b1;
                end

                if (start) begin
                    state_nx = pick_d ? DATA : FETCH;
                end
            end

            FETCH, DATA: begin
                if (wait_cnt == TIMEOUT_CNT) begin
                    timed_out = 1'b1;
                    state_nx  = DONE;
                end else if ((bus_ren || bus_wen) && !bus_busy) begin
                    complete  = 1'b1;
                    state_nx  = DONE;
                end
            end

            DONE: begin
                // Requests still high here are ignored; they must be seen
                // again in IDLE to start a new access.
                state_nx = IDLE;
            end

            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // Bus outputs: address/data latched at grant, strobe held until the access ends.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus_ren   <= 1'b0;
            bus_wen   <= 1'b0;
            bus_addr  <= '0;
            bus_wdata <= '0;
        end else if (start) begin
            bus_addr  <= pick_d ? d_addr : i_addr;
            bus_wdata <= pick_d ? d_wdata : '0;
            // Fetch always reads; data reads unless a write is requested.
            bus_ren   <= ~pick_d | ~d_wen;
            bus_wen   <= pick_d & d_wen;
        end else if (complete || timed_out) begin
            bus_ren   <= 1'b0;
            bus_wen   <= 1'b0;
        end
    end

    // Wait counter: cleared on every grant, counts busy cycles, saturates at the limit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt <= '0;
        end else if (start) begin
            wait_cnt <= '0;
        end else if (in_access && bus_busy && (wait_cnt != TIMEOUT_CNT)) begin
            wait_cnt <= wait_cnt + 8'd1;
        end
    end

    // Ownership of the current access, its abort flag, and round-robin history.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grant_d      <= 1'b0;
            aborted      <= 1'b0;
            last_grant_d <= 1'b1;   // "data" last, so fetch wins the first tie
        end else begin
            if (start) begin
                grant_d <= pick_d;
                aborted <= 1'b0;
            end else if (timed_out) begin
                aborted <= 1'b1;
            end

            if (in_done) begin
                last_grant_d <= grant_d;
            end
        end
    end

    // Holding register captures the bus result; per-side copies keep it after DONE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_q    <= '0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
        end else begin
            if (timed_out) begin
                hold_q <= '0;
            end else if (complete) begin
                hold_q <= bus_wen ? '0 : bus_rdata;
            end

            if (in_done) begin
                if (grant_d) begin
                    d_rdata_q <= hold_q;
                end else begin
                    i_rdata_q <= hold_q;
                end
            end
        end
    end

    // Completion pulses come straight from DONE so they carry no extra latency.
    assign i_ready = in_done & ~grant_d;
    assign d_ready = in_done & grant_d;
    assign err     = in_done & aborted;

    // During the ready pulse the fresh result is forwarded; otherwise the
    // previously delivered value is held.
    assign i_rdata = i_ready ? hold_q : i_rdata_q;
    assign d_rdata = d_ready ? hold_q : d_rdata_q;

    // Core stall: any request that is not completing this cycle.
    assign stall = (i_req & ~i_ready) | (d_req & ~d_ready);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
// Directed stimulus drives the arbiter and pushes the expected completion
// (which side, data, err, cycle) into a scoreboard queue. A monitor running on
// the falling edge pops an entry whenever a ready pulse appears and compares.
// Bus-side strobe/address timing is checked inline by the stimulus process.

module tb_mem_port_arbiter;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_req;
    logic [31:0] i_addr;
    logic [31:0] i_rdata;
    logic        i_ready;
    logic        d_ren;
    logic        d_wen;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_ready;
    logic        bus_ren;
    logic        bus_wen;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    logic        bus_busy;
    logic        stall;
    logic        err;

    // Memory model: returns a fixed override word, or a pattern derived from the address.
    logic [31:0] rd_override;
    logic        rd_override_en;
    always_comb bus_rdata = rd_override_en ? rd_override : {bus_addr[15:0], 16'hC0DE};

    mem_port_arbiter #(.TIMEOUT(TO)) dut (
        .clk       (clk),
        .rst       (rst),
        .i_req     (i_req),
        .i_addr    (i_addr),
        .i_rdata   (i_rdata),
        .i_ready   (i_ready),
        .d_ren     (d_ren),
        .d_wen     (d_wen),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_rdata   (d_rdata),
        .d_ready   (d_ready),
        .bus_ren   (bus_ren),
        .bus_wen   (bus_wen),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_rdata (bus_rdata),
        .bus_busy  (bus_busy),
        .stall     (stall),
        .err       (err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [1:0]  rdy;    // {d_ready, i_ready}
        logic [31:0] rdata;
        logic        err;
        int          at;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic expect_rsp(input logic [1:0] rdy, input logic [31:0] d, input logic e, input int at);
        exp_t x;
        x.rdy   = rdy;
        x.rdata = d;
        x.err   = e;
        x.at    = at;
        sb.push_back(x);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every ready pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && (i_ready || d_ready)) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_ready: got {d_ready,i_ready}=%b, expected none (cycle %0d)",
                         {d_ready, i_ready}, cyc);
            end else begin
                e = sb.pop_front();
                check("ready_side", 32'({d_ready, i_ready}), 32'(e.rdy));
                check("ready_cycle", 32'(cyc), 32'(e.at));
                check("ready_rdata", e.rdy[1] ? d_rdata : i_rdata, e.rdata);
                check("ready_err", 32'(err), 32'(e.err));
            end
        end else if (!rst && err) begin
            check("err_without_ready", 32'(err), 32'd0);
        end
    end

    initial begin
        int k;
        rst            = 1'b1;
        i_req          = 1'b0;
        i_addr         = '0;
        d_ren          = 1'b0;
        d_wen          = 1'b0;
        d_addr         = '0;
        d_wdata        = '0;
        bus_busy       = 1'b0;
        rd_override    = '0;
        rd_override_en = 1'b0;

        // Reset values
        tick();
        tick();
        check("rst_bus_ren", 32'(bus_ren), 32'd0);
        check("rst_bus_wen", 32'(bus_wen), 32'd0);
        check("rst_bus_addr", bus_addr, 32'd0);
        check("rst_bus_wdata", bus_wdata, 32'd0);
        check("rst_readies", 32'({i_ready, d_ready, err}), 32'd0);
        check("rst_i_rdata", i_rdata, 32'd0);
        check("rst_d_rdata", d_rdata, 32'd0);
        i_req = 1'b1;
        #1;
        check("rst_stall_follows_req", 32'(stall), 32'd1);
        i_req = 1'b0;
        #1;
        check("rst_stall_idle", 32'(stall), 32'd0);
        tick();
        rst = 1'b0;
        tick();

        // Tie held continuously after reset: fetch, data, fetch, data
        k      = cyc;
        i_req  = 1'b1;
        d_ren  = 1'b1;
        i_addr = 32'h0000_0040;
        d_addr = 32'h0000_0080;
        expect_rsp(2'b01, 32'h0040_C0DE, 1'b0, k + 2);
        expect_rsp(2'b10, 32'h0080_C0DE, 1'b0, k + 5);
        expect_rsp(2'b01, 32'h0040_C0DE, 1'b0, k + 8);
        expect_rsp(2'b10, 32'h0080_C0DE, 1'b0, k + 11);
        tick();
        check("tie_first_ren", 32'(bus_ren), 32'd1);
        check("tie_first_addr", bus_addr, 32'h0000_0040);
        repeat (3) tick();
        check("tie_second_ren", 32'(bus_ren), 32'd1);
        check("tie_second_addr", bus_addr, 32'h0000_0080);
        repeat (7) tick();
        i_req = 1'b0;
        d_ren = 1'b0;
        tick();

        // Zero-wait fetch
        k              = cyc;
        i_req          = 1'b1;
        i_addr         = 32'h0000_0004;
        rd_override    = 32'h3E80_0093;
        rd_override_en = 1'b1;
        expect_rsp(2'b01, 32'h3E80_0093, 1'b0, k + 2);
        #1;
        check("fetch_stall_pending", 32'(stall), 32'd1);
        tick();
        check("fetch_bus_ren", 32'(bus_ren), 32'd1);
        check("fetch_bus_wen", 32'(bus_wen), 32'd0);
        check("fetch_bus_addr", bus_addr, 32'h0000_0004);
        tick();
        i_req          = 1'b0;
        rd_override_en = 1'b0;
        tick();
        check("fetch_stall_after", 32'(stall), 32'd0);

        // Store with three wait cycles
        k        = cyc;
        d_wen    = 1'b1;
        d_addr   = 32'h0000_0100;
        d_wdata  = 32'hDEAD_BEEF;
        bus_busy = 1'b1;
        expect_rsp(2'b10, 32'h0000_0000, 1'b0, k + 5);
        for (int i = 1; i <= 4; i++) begin
            tick();
            check("store_bus_wen", 32'(bus_wen), 32'd1);
            check("store_bus_wdata", bus_wdata, 32'hDEAD_BEEF);
            check("store_bus_addr", bus_addr, 32'h0000_0100);
            if (i == 4) bus_busy = 1'b0;
        end
        tick();
        check("store_done_wen_low", 32'(bus_wen), 32'd0);
        d_wen = 1'b0;
        tick();

        // Read and write both requested: treated as a write
        k       = cyc;
        d_ren   = 1'b1;
        d_wen   = 1'b1;
        d_addr  = 32'h0000_0200;
        d_wdata = 32'h0BAD_F00D;
        expect_rsp(2'b10, 32'h0000_0000, 1'b0, k + 2);
        tick();
        check("rw_bus_wen", 32'(bus_wen), 32'd1);
        check("rw_bus_ren", 32'(bus_ren), 32'd0);
        check("rw_bus_wdata", bus_wdata, 32'h0BAD_F00D);
        tick();
        d_ren = 1'b0;
        d_wen = 1'b0;
        tick();

        // Timeout with the bus stuck busy, then a normal load
        k        = cyc;
        d_ren    = 1'b1;
        d_addr   = 32'h0000_0300;
        bus_busy = 1'b1;
        expect_rsp(2'b10, 32'h0000_0000, 1'b1, k + TO + 2);
        for (int i = 1; i <= TO + 1; i++) begin
            tick();
            check("timeout_bus_ren", 32'(bus_ren), 32'd1);
        end
        tick();
        check("timeout_done_ren_low", 32'(bus_ren), 32'd0);
        d_ren    = 1'b0;
        bus_busy = 1'b0;
        tick();
        k      = cyc;
        d_ren  = 1'b1;
        d_addr = 32'h0000_1234;
        expect_rsp(2'b10, 32'h1234_C0DE, 1'b0, k + 2);
        tick();
        tick();
        d_ren = 1'b0;
        tick();
        check("load_rdata_held", d_rdata, 32'h1234_C0DE);

        // Reset in the middle of a busy data access
        d_ren    = 1'b1;
        d_addr   = 32'h0000_0400;
        bus_busy = 1'b1;
        tick();
        check("midrst_bus_ren_before", 32'(bus_ren), 32'd1);
        tick();
        rst = 1'b1;
        #1;
        check("midrst_bus_ren_dropped", 32'(bus_ren), 32'd0);
        check("midrst_no_ready", 32'({i_ready, d_ready}), 32'd0);
        d_ren    = 1'b0;
        bus_busy = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        tick();

        // After reset fetch wins the first tie
        k      = cyc;
        i_req  = 1'b1;
        d_ren  = 1'b1;
        i_addr = 32'h0000_0500;
        d_addr = 32'h0000_0600;
        expect_rsp(2'b01, 32'h0500_C0DE, 1'b0, k + 2);
        tick();
        check("postrst_tie_ren", 32'(bus_ren), 32'd1);
        check("postrst_tie_addr", bus_addr, 32'h0000_0500);
        tick();
        i_req = 1'b0;
        d_ren = 1'b0;
        repeat (4) tick();

        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
